// File: rtl/plca_txop_claim_table.sv
// PLCA TXOP ownership table: FREE/SOFT/HARD claim per TXOP ID, highest-HARD tracking, free-ID scan.
// Optional macro PLCA_TXOP_RANDOM_PICK_EN: LFSR-chosen start ID for the PICK_FREE scan.
`timescale 1ns/1ps
module plca_txop_claim_table #(
   parameter int NODE_CNT = 32,
   parameter int ID_W     = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      cmd_op,
   input  logic [ID_W-1:0] cmd_id,
   output logic            rsp_valid,
   output logic            rsp_found,
   output logic [ID_W-1:0] rsp_id,
   input  logic [ID_W-1:0] query_id,
   output logic            hard_claiming,
   output logic            soft_claiming,
   output logic [ID_W-1:0] max_hard_claim,
   output logic            busy
);

   localparam int IDX_W = (NODE_CNT > 2) ? $clog2(NODE_CNT) : 1;
   localparam logic [ID_W-1:0] ONE_ID    = ID_W'(1);
   localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NODE_CNT - 1);
   localparam logic [ID_W-1:0] SCAN_LAST = ID_W'(NODE_CNT - 2);

   localparam logic [1:0] E_FREE = 2'd0;
   localparam logic [1:0] E_SOFT = 2'd1;
   localparam logic [1:0] E_HARD = 2'd2;

   localparam logic [2:0] OP_CLEAR_TABLE = 3'd0;
   localparam logic [2:0] OP_CLEAR_SOFT  = 3'd1;
   localparam logic [2:0] OP_SET_SOFT    = 3'd2;
   localparam logic [2:0] OP_SET_HARD    = 3'd3;
   localparam logic [2:0] OP_RELEASE     = 3'd4;
   localparam logic [2:0] OP_PICK_FREE   = 3'd5;

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN_FREE, ST_SCAN_MAX} state_t;

   // Handshake: a command is taken on the edge where cmd_valid && cmd_ready; the
   // requester must hold it while cmd_ready is low. rsp_valid is a one-cycle pulse.
   state_t           state_q, state_d;
   logic [1:0]       tbl [NODE_CNT];
   logic [ID_W-1:0]  scan_ptr;
   logic [ID_W-1:0]  scan_cnt;
   logic [ID_W-1:0]  start_id;
   logic             accept;
   logic             cmd_id_ok, query_ok;
   logic [IDX_W-1:0] cmd_idx, query_idx, scan_idx;
   logic             release_scan, free_hit, hard_hit;

   assign cmd_id_ok    = (cmd_id != '0) && (cmd_id <= LAST_ID);
   assign query_ok     = (query_id != '0) && (query_id <= LAST_ID);
   assign cmd_idx      = cmd_id[IDX_W-1:0];
   assign query_idx    = query_id[IDX_W-1:0];
   assign scan_idx     = scan_ptr[IDX_W-1:0];
   assign free_hit     = (tbl[scan_idx] == E_FREE);
   assign hard_hit     = (tbl[scan_idx] == E_HARD);
   // Releasing the current maximum leaves a hole only a downward search can resolve.
   assign release_scan = cmd_id_ok && (tbl[cmd_idx] == E_HARD) &&
                         (cmd_id == max_hard_claim) && (cmd_id > ONE_ID);

`ifdef PLCA_TXOP_RANDOM_PICK_EN
   logic [7:0]      lfsr_q;
   logic [ID_W-1:0] lfsr_id;

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= 8'h01;
      else       lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
   end

   always_comb begin
      lfsr_id = '0;
      for (int b = 0; b < ID_W && b < 8; b++) lfsr_id[b] = lfsr_q[b];
   end

   assign start_id = ((lfsr_id == '0) || (lfsr_id > LAST_ID)) ? ONE_ID : lfsr_id;
`else
   assign start_id = ONE_ID;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (cmd_op == OP_PICK_FREE)                     state_d = ST_SCAN_FREE;
               else if (cmd_op == OP_RELEASE && release_scan)  state_d = ST_SCAN_MAX;
            end
         end
         ST_SCAN_FREE: if (free_hit || scan_cnt == SCAN_LAST) state_d = ST_IDLE;
         ST_SCAN_MAX:  if (hard_hit || scan_ptr == ONE_ID)     state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == ST_IDLE);
      busy      = (state_q != ST_IDLE);
      accept    = cmd_valid && (state_q == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NODE_CNT; i++) tbl[i] <= E_FREE;
         max_hard_claim <= '0;
         rsp_valid      <= 1'b0;
         rsp_found      <= 1'b0;
         rsp_id         <= '0;
         hard_claiming  <= 1'b0;
         soft_claiming  <= 1'b0;
         scan_ptr       <= '0;
         scan_cnt       <= '0;
      end else begin
         rsp_valid     <= 1'b0;
         rsp_found     <= 1'b0;
         rsp_id        <= '0;
         hard_claiming <= query_ok && (tbl[query_idx] == E_HARD);
         soft_claiming <= query_ok && (tbl[query_idx] == E_SOFT);
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  case (cmd_op)
                     OP_CLEAR_TABLE: begin
                        for (int i = 0; i < NODE_CNT; i++) tbl[i] <= E_FREE;
                        max_hard_claim <= '0;
                        rsp_valid      <= 1'b1;
                     end
                     OP_CLEAR_SOFT: begin
                        for (int i = 0; i < NODE_CNT; i++)
                           if (tbl[i] == E_SOFT) tbl[i] <= E_FREE;
                        rsp_valid <= 1'b1;
                     end
                     OP_SET_SOFT: begin
                        if (cmd_id_ok && tbl[cmd_idx] == E_FREE) tbl[cmd_idx] <= E_SOFT;
                        rsp_valid <= 1'b1;
                     end
                     OP_SET_HARD: begin
                        if (cmd_id_ok) begin
                           tbl[cmd_idx] <= E_HARD;
                           if (cmd_id > max_hard_claim) max_hard_claim <= cmd_id;
                        end
                        rsp_valid <= 1'b1;
                     end
                     OP_RELEASE: begin
                        if (cmd_id_ok) tbl[cmd_idx] <= E_FREE;
                        if (release_scan) begin
                           scan_ptr <= cmd_id - ONE_ID;
                        end else begin
                           rsp_valid <= 1'b1;
                           if (cmd_id_ok && tbl[cmd_idx] == E_HARD && cmd_id == max_hard_claim)
                              max_hard_claim <= '0;
                        end
                     end
                     OP_PICK_FREE: begin
                        scan_ptr <= start_id;
                        scan_cnt <= '0;
                     end
                     default: rsp_valid <= 1'b1;
                  endcase
               end
            end
            ST_SCAN_FREE: begin
               if (free_hit) begin
                  rsp_valid <= 1'b1;
                  rsp_found <= 1'b1;
                  rsp_id    <= scan_ptr;
               end else if (scan_cnt == SCAN_LAST) begin
                  rsp_valid <= 1'b1;
               end else begin
                  scan_ptr <= (scan_ptr == LAST_ID) ? ONE_ID : scan_ptr + ONE_ID;
                  scan_cnt <= scan_cnt + ONE_ID;
               end
            end
            ST_SCAN_MAX: begin
               if (hard_hit) begin
                  max_hard_claim <= scan_ptr;
                  rsp_valid      <= 1'b1;
               end else if (scan_ptr == ONE_ID) begin
                  max_hard_claim <= '0;
                  rsp_valid      <= 1'b1;
               end else begin
                  scan_ptr <= scan_ptr - ONE_ID;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
